wb_ctrl_sequencer: RTL and testbench

Master-side driver of `wb_ctrl_if` for the white-balance corrector, sitting between the CPU-facing configuration write port and the corrector's control input. Software writes mode, manual R/G/B coefficients and calibration requests into shadow registers. The block applies them atomically at the next start of frame, serialising coefficient updates as `man_sel`/`man_coef`/`man_lock` strobes. It also generates a frame-aligned, delayed `cal_stb` pulse.

---
 rtl/wb_ctrl_pkg.sv | 40 ++++
 rtl/wb_ctrl_if.sv | 13 +
 rtl/wb_cal_timer.sv | 44 ++++
 rtl/wb_ctrl_sequencer.sv | 131 +++++++++++++
 tb/tb_wb_ctrl_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_ctrl_pkg.sv
// Shared types and constants for the white-balance control sequencer.
package wb_ctrl_pkg;

    localparam int unsigned CFG_ADDR_W = 3;
    localparam int unsigned CFG_DATA_W = 32;

    typedef enum logic [1:0] {
        MODE_AUTO_GW      = 2'd0,
        MODE_AUTO_RETINEX = 2'd1,
        MODE_MANUAL       = 2'd2,
        MODE_CALIBRATION  = 2'd3
    } wb_mode_e;

    localparam logic [1:0] SEL_RED   = 2'd0;
    localparam logic [1:0] SEL_GREEN = 2'd1;
    localparam logic [1:0] SEL_BLUE  = 2'd2;

    localparam logic [CFG_ADDR_W-1:0] ADDR_MODE    = 3'd0;
    localparam logic [CFG_ADDR_W-1:0] ADDR_R_COEF  = 3'd1;
    localparam logic [CFG_ADDR_W-1:0] ADDR_G_COEF  = 3'd2;
    localparam logic [CFG_ADDR_W-1:0] ADDR_B_COEF  = 3'd3;
    localparam logic [CFG_ADDR_W-1:0] ADDR_CAL_REQ = 3'd4;
    localparam logic [CFG_ADDR_W-1:0] ADDR_COMMIT  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEND_R = 2'd1,
        ST_SEND_G = 2'd2,
        ST_SEND_B = 2'd3
    } wb_seq_state_e;

    // Lowest dirty channel in R, G, B order; bit 0 = R, bit 1 = G, bit 2 = B.
    function automatic wb_seq_state_e first_dirty(input logic [2:0] dirty);
        if (dirty[0])      return ST_SEND_R;
        else if (dirty[1]) return ST_SEND_G;
        else if (dirty[2]) return ST_SEND_B;
        else               return ST_IDLE;
    endfunction

endpackage

// File: rtl/wb_ctrl_if.sv
// Control bundle from the sequencer to the white-balance corrector.
interface wb_ctrl_if #(
    parameter int unsigned COEF_WIDTH = 32
);
    logic [1:0]            mode;
    logic [1:0]            man_sel;
    logic [COEF_WIDTH-1:0] man_coef;
    logic                  man_lock;
    logic                  cal_stb;

    modport master (output mode, man_sel, man_coef, man_lock, cal_stb);
    modport slave  (input  mode, man_sel, man_coef, man_lock, cal_stb);
endinterface

// File: rtl/wb_cal_timer.sv
// Frame-counting calibration strobe: fires on the (N+1)-th SOF after a request.
module wb_cal_timer #(
    parameter int unsigned SETTLE_WIDTH = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    sof_i,
    input  logic                    accept_i,
    input  logic [SETTLE_WIDTH-1:0] settle_i,
    input  logic                    abort_i,
    output logic                    cal_stb_o
);

    logic                    pending_q;
    logic [SETTLE_WIDTH-1:0] cnt_q;
    logic                    stb_q;

    // Abort beats a coincident request; a new request reloads the count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending_q <= 1'b0;
            cnt_q     <= '0;
            stb_q     <= 1'b0;
        end else begin
            stb_q <= 1'b0;
            if (abort_i) begin
                pending_q <= 1'b0;
            end else if (accept_i) begin
                pending_q <= 1'b1;
                cnt_q     <= settle_i;
            end else if (sof_i && pending_q) begin
                if (cnt_q == '0) begin
                    stb_q     <= 1'b1;
                    pending_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_q - SETTLE_WIDTH'(1);
                end
            end
        end
    end

    assign cal_stb_o = stb_q;

endmodule

// File: rtl/wb_ctrl_sequencer.sv
// Shadows CPU config writes and applies them atomically at start of frame,
// serialising dirty coefficients as man_lock strobes.
module wb_ctrl_sequencer
    import wb_ctrl_pkg::*;
#(
    parameter int unsigned COEF_WIDTH   = 32,
    parameter int unsigned SETTLE_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  sof_i,
    input  logic                  cfg_wr_i,
    input  logic [CFG_ADDR_W-1:0] cfg_addr_i,
    input  logic [CFG_DATA_W-1:0] cfg_data_i,
    output logic                  cfg_ready_o,
    wb_ctrl_if.master             wb_ctrl_o
);

    wb_mode_e              mode_sh_q, mode_q;
    logic [COEF_WIDTH-1:0] r_sh_q, g_sh_q, b_sh_q;
    logic [COEF_WIDTH-1:0] r_send_q, g_send_q, b_send_q;
    logic [COEF_WIDTH-1:0] man_coef_q, coef_d;
    logic [2:0]            dirty_q, dirty_d, send_dirty_q, remain_d;
    logic                  commit_armed_q, commit_armed_d;
    wb_seq_state_e         state_q, state_d;
    logic [1:0]            man_sel_q, sel_d;
    logic                  man_lock_q, cfg_ready_q;
    logic                  wr_acc, commit, cal_accept, cal_abort, cal_stb;

    // Next burst step and shadow bookkeeping; commit snapshots pre-write values.
    always_comb begin
        wr_acc         = cfg_wr_i && cfg_ready_q;
        commit         = (state_q == ST_IDLE) && sof_i && commit_armed_q;
        dirty_d        = commit ? 3'b000 : dirty_q;
        commit_armed_d = commit ? 1'b0 : commit_armed_q;
        if (wr_acc) begin
            case (cfg_addr_i)
                ADDR_R_COEF: dirty_d[0]     = 1'b1;
                ADDR_G_COEF: dirty_d[1]     = 1'b1;
                ADDR_B_COEF: dirty_d[2]     = 1'b1;
                ADDR_COMMIT: commit_armed_d = 1'b1;
                default:     ;
            endcase
        end

        case (state_q)
            ST_IDLE:   remain_d = commit ? dirty_q : 3'b000;
            ST_SEND_R: remain_d = send_dirty_q & 3'b110;
            ST_SEND_G: remain_d = send_dirty_q & 3'b100;
            default:   remain_d = 3'b000;
        endcase
        state_d = first_dirty(remain_d);

        sel_d  = man_sel_q;
        coef_d = man_coef_q;
        case (state_d)
            ST_SEND_R: begin sel_d = SEL_RED;   coef_d = commit ? r_sh_q : r_send_q; end
            ST_SEND_G: begin sel_d = SEL_GREEN; coef_d = commit ? g_sh_q : g_send_q; end
            ST_SEND_B: begin sel_d = SEL_BLUE;  coef_d = commit ? b_sh_q : b_send_q; end
            default:   ;
        endcase

        cal_accept = wr_acc && (cfg_addr_i == ADDR_CAL_REQ) && (mode_q == MODE_CALIBRATION);
        cal_abort  = commit && (mode_q == MODE_CALIBRATION) && (mode_sh_q != MODE_CALIBRATION);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mode_sh_q      <= MODE_AUTO_GW;
            mode_q         <= MODE_AUTO_GW;
            r_sh_q         <= '0;
            g_sh_q         <= '0;
            b_sh_q         <= '0;
            r_send_q       <= '0;
            g_send_q       <= '0;
            b_send_q       <= '0;
            dirty_q        <= 3'b000;
            send_dirty_q   <= 3'b000;
            commit_armed_q <= 1'b0;
            state_q        <= ST_IDLE;
            man_lock_q     <= 1'b0;
            man_sel_q      <= 2'd0;
            man_coef_q     <= '0;
            cfg_ready_q    <= 1'b1;
        end else begin
            if (wr_acc) begin
                case (cfg_addr_i)
                    ADDR_MODE:   mode_sh_q <= wb_mode_e'(cfg_data_i[1:0]);
                    ADDR_R_COEF: r_sh_q    <= cfg_data_i[COEF_WIDTH-1:0];
                    ADDR_G_COEF: g_sh_q    <= cfg_data_i[COEF_WIDTH-1:0];
                    ADDR_B_COEF: b_sh_q    <= cfg_data_i[COEF_WIDTH-1:0];
                    default:     ;
                endcase
            end
            dirty_q        <= dirty_d;
            commit_armed_q <= commit_armed_d;
            if (commit) begin
                r_send_q     <= r_sh_q;
                g_send_q     <= g_sh_q;
                b_send_q     <= b_sh_q;
                send_dirty_q <= dirty_q;
                mode_q       <= mode_sh_q;
            end
            state_q     <= state_d;
            man_lock_q  <= (state_d != ST_IDLE);
            man_sel_q   <= sel_d;
            man_coef_q  <= coef_d;
            cfg_ready_q <= (state_d == ST_IDLE);
        end
    end

    wb_cal_timer #(
        .SETTLE_WIDTH (SETTLE_WIDTH)
    ) u_cal_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .sof_i     (sof_i),
        .accept_i  (cal_accept),
        .settle_i  (cfg_data_i[SETTLE_WIDTH-1:0]),
        .abort_i   (cal_abort),
        .cal_stb_o (cal_stb)
    );

    assign cfg_ready_o        = cfg_ready_q;
    assign wb_ctrl_o.mode     = mode_q;
    assign wb_ctrl_o.man_sel  = man_sel_q;
    assign wb_ctrl_o.man_coef = man_coef_q;
    assign wb_ctrl_o.man_lock = man_lock_q;
    assign wb_ctrl_o.cal_stb  = cal_stb;

endmodule

// File: tb/tb_wb_ctrl_sequencer.sv
// Bench for wb_ctrl_sequencer: expected man_lock beats are queued as commits are staged.
module tb_wb_ctrl_sequencer;

    typedef struct packed {
        logic [1:0]  sel;
        logic [31:0] coef;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sof = 1'b0;
    logic        wr = 1'b0;
    logic [2:0]  addr = 3'd0;
    logic [31:0] data = 32'd0;
    logic        ready;

    int    errors = 0;
    int    checks = 0;
    int    cal_seen = 0;
    beat_t exp_q[$];
    beat_t got_b;

    wb_ctrl_if #(.COEF_WIDTH(32)) wb_if ();

    wb_ctrl_sequencer #(.COEF_WIDTH(32), .SETTLE_WIDTH(8)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .sof_i       (sof),
        .cfg_wr_i    (wr),
        .cfg_addr_i  (addr),
        .cfg_data_i  (data),
        .cfg_ready_o (ready),
        .wb_ctrl_o   (wb_if)
    );

    always #5 clk = ~clk;

    // Scoreboard: every observed man_lock beat must match the queue head.
    always @(negedge clk) begin
        if (!rst && wb_if.man_lock) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got sel=%0d coef=%h, required no beat", wb_if.man_sel, wb_if.man_coef);
            end else begin
                got_b = exp_q.pop_front();
                if (wb_if.man_sel !== got_b.sel || wb_if.man_coef !== got_b.coef) begin
                    errors++;
                    $display("FAIL sb_beat: got sel=%0d coef=%h, required sel=%0d coef=%h",
                             wb_if.man_sel, wb_if.man_coef, got_b.sel, got_b.coef);
                end
            end
        end
        if (!rst && wb_if.cal_stb) cal_seen++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
        int n = 0;
        wr = 1'b1; addr = a; data = d;
        while (!ready && n < 50) begin tick(); n++; end
        if (!ready) begin
            checks++; errors++;
            $display("FAIL write_timeout: ready=%0b, required 1 within 50 cycles", ready);
        end else begin
            tick();
        end
        wr = 1'b0;
    endtask

    task automatic pulse_sof();
        sof = 1'b1;
        tick();
        sof = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        checks++;
        if (wb_if.mode !== 2'd0 || wb_if.man_sel !== 2'd0 || wb_if.man_coef !== 32'd0 ||
            wb_if.man_lock !== 1'b0 || wb_if.cal_stb !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_values: got mode=%0d sel=%0d coef=%h lock=%0b stb=%0b ready=%0b, required 0 0 0 0 0 1",
                     wb_if.mode, wb_if.man_sel, wb_if.man_coef, wb_if.man_lock, wb_if.cal_stb, ready);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (wb_if.man_lock !== 1'b0 || ready !== 1'b1 || wb_if.mode !== 2'd0) begin
                errors++;
                $display("FAIL reset_idle: cycle %0d lock=%0b ready=%0b mode=%0d, required 0 1 0",
                         i, wb_if.man_lock, ready, wb_if.mode);
            end
        end
    endtask

    task automatic test_burst();
        cfg_write(3'd1, 32'h0000_0C00);
        cfg_write(3'd3, 32'h0000_0800);
        cfg_write(3'd0, 32'd2);
        cfg_write(3'd5, 32'd0);
        exp_q.push_back('{sel: 2'd0, coef: 32'h0C00});
        exp_q.push_back('{sel: 2'd2, coef: 32'h0800});
        pulse_sof();
        checks++;
        if (wb_if.mode !== 2'd2 || wb_if.man_lock !== 1'b1 || wb_if.man_sel !== 2'd0 ||
            wb_if.man_coef !== 32'h0C00 || ready !== 1'b0) begin
            errors++;
            $display("FAIL burst_t1: got mode=%0d lock=%0b sel=%0d coef=%h ready=%0b, required 2 1 0 00000c00 0",
                     wb_if.mode, wb_if.man_lock, wb_if.man_sel, wb_if.man_coef, ready);
        end
        tick();
        checks++;
        if (wb_if.man_lock !== 1'b1 || wb_if.man_sel !== 2'd2 || wb_if.man_coef !== 32'h0800 || ready !== 1'b0) begin
            errors++;
            $display("FAIL burst_t2: got lock=%0b sel=%0d coef=%h ready=%0b, required 1 2 00000800 0",
                     wb_if.man_lock, wb_if.man_sel, wb_if.man_coef, ready);
        end
        tick();
        checks++;
        if (wb_if.man_lock !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL burst_t3: got lock=%0b ready=%0b, required 0 1", wb_if.man_lock, ready);
        end
        repeat (2) tick();
    endtask

    task automatic test_stall();
        cfg_write(3'd2, 32'h0000_0400);
        cfg_write(3'd5, 32'd0);
        exp_q.push_back('{sel: 2'd1, coef: 32'h0400});
        pulse_sof();
        checks++;
        if (wb_if.man_lock !== 1'b1 || wb_if.man_sel !== 2'd1 || ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_g: got lock=%0b sel=%0d ready=%0b, required 1 1 0", wb_if.man_lock, wb_if.man_sel, ready);
        end
        wr = 1'b1; addr = 3'd1; data = 32'h0000_0123;
        tick();
        checks++;
        if (ready !== 1'b1 || wb_if.man_lock !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: got ready=%0b lock=%0b, required 1 0", ready, wb_if.man_lock);
        end
        tick();
        wr = 1'b0;
        repeat (3) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL stall_pending: got %0d queued beats, required 0", exp_q.size());
        end
        cfg_write(3'd5, 32'd0);
        exp_q.push_back('{sel: 2'd0, coef: 32'h0123});
        pulse_sof();
        checks++;
        if (wb_if.man_lock !== 1'b1 || wb_if.man_sel !== 2'd0 || wb_if.man_coef !== 32'h0123) begin
            errors++;
            $display("FAIL stall_r: got lock=%0b sel=%0d coef=%h, required 1 0 00000123",
                     wb_if.man_lock, wb_if.man_sel, wb_if.man_coef);
        end
        tick();
        checks++;
        if (wb_if.man_lock !== 1'b0) begin
            errors++;
            $display("FAIL stall_r_only: got lock=%0b, required 0", wb_if.man_lock);
        end
        repeat (2) tick();
    endtask

    task automatic test_cal();
        int base;
        cfg_write(3'd0, 32'd3);
        cfg_write(3'd5, 32'd0);
        pulse_sof();
        checks++;
        if (wb_if.mode !== 2'd3 || wb_if.man_lock !== 1'b0) begin
            errors++;
            $display("FAIL cal_mode: got mode=%0d lock=%0b, required 3 0", wb_if.mode, wb_if.man_lock);
        end
        tick();
        cfg_write(3'd4, 32'd2);
        base = cal_seen;
        for (int i = 1; i <= 3; i++) begin
            repeat (3) tick();
            pulse_sof();
            checks++;
            if (wb_if.cal_stb !== ((i == 3) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL cal_stb_sof%0d: got %0b, required %0b", i, wb_if.cal_stb, (i == 3));
            end
        end
        tick();
        checks++;
        if (wb_if.cal_stb !== 1'b0) begin
            errors++;
            $display("FAIL cal_stb_width: got %0b, required 0", wb_if.cal_stb);
        end
        repeat (3) tick();
        pulse_sof();
        repeat (2) tick();
        checks++;
        if (cal_seen - base != 1) begin
            errors++;
            $display("FAIL cal_count: got %0d pulses, required 1", cal_seen - base);
        end
    endtask

    task automatic test_cal_ignored();
        int base;
        cfg_write(3'd0, 32'd0);
        cfg_write(3'd5, 32'd0);
        pulse_sof();
        checks++;
        if (wb_if.mode !== 2'd0) begin
            errors++;
            $display("FAIL calign_mode: got mode=%0d, required 0", wb_if.mode);
        end
        tick();
        cfg_write(3'd4, 32'd0);
        base = cal_seen;
        for (int i = 0; i < 5; i++) begin
            repeat (3) tick();
            pulse_sof();
        end
        repeat (2) tick();
        checks++;
        if (cal_seen != base) begin
            errors++;
            $display("FAIL calign_count: got %0d pulses, required 0", cal_seen - base);
        end
    endtask

    task automatic test_commit_same_cycle();
        cfg_write(3'd0, 32'd2);
        cfg_write(3'd3, 32'h0000_0055);
        wr = 1'b1; addr = 3'd5; data = 32'd0; sof = 1'b1;
        tick();
        wr = 1'b0; sof = 1'b0;
        checks++;
        if (wb_if.mode !== 2'd0 || wb_if.man_lock !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL same_cycle_hold: got mode=%0d lock=%0b ready=%0b, required 0 0 1",
                     wb_if.mode, wb_if.man_lock, ready);
        end
        repeat (3) tick();
        exp_q.push_back('{sel: 2'd2, coef: 32'h0055});
        pulse_sof();
        checks++;
        if (wb_if.mode !== 2'd2 || wb_if.man_lock !== 1'b1 || wb_if.man_sel !== 2'd2 || wb_if.man_coef !== 32'h0055) begin
            errors++;
            $display("FAIL same_cycle_apply: got mode=%0d lock=%0b sel=%0d coef=%h, required 2 1 2 00000055",
                     wb_if.mode, wb_if.man_lock, wb_if.man_sel, wb_if.man_coef);
        end
        repeat (3) tick();
    endtask

    task automatic test_write_at_sof();
        cfg_write(3'd1, 32'h0000_0011);
        cfg_write(3'd5, 32'd0);
        exp_q.push_back('{sel: 2'd0, coef: 32'h0011});
        wr = 1'b1; addr = 3'd3; data = 32'h0000_0022; sof = 1'b1;
        tick();
        wr = 1'b0; sof = 1'b0;
        checks++;
        if (wb_if.man_lock !== 1'b1 || wb_if.man_sel !== 2'd0 || wb_if.man_coef !== 32'h0011) begin
            errors++;
            $display("FAIL sofwr_r: got lock=%0b sel=%0d coef=%h, required 1 0 00000011",
                     wb_if.man_lock, wb_if.man_sel, wb_if.man_coef);
        end
        tick();
        checks++;
        if (wb_if.man_lock !== 1'b0) begin
            errors++;
            $display("FAIL sofwr_no_b: got lock=%0b, required 0", wb_if.man_lock);
        end
        cfg_write(3'd5, 32'd0);
        exp_q.push_back('{sel: 2'd2, coef: 32'h0022});
        pulse_sof();
        checks++;
        if (wb_if.man_lock !== 1'b1 || wb_if.man_sel !== 2'd2 || wb_if.man_coef !== 32'h0022) begin
            errors++;
            $display("FAIL sofwr_b: got lock=%0b sel=%0d coef=%h, required 1 2 00000022",
                     wb_if.man_lock, wb_if.man_sel, wb_if.man_coef);
        end
        repeat (3) tick();
    endtask

    initial begin
        test_reset();
        test_burst();
        test_stall();
        test_cal();
        test_cal_ignored();
        test_commit_same_cycle();
        test_write_at_sof();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d unsent beats, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
